// File: rtl/rv32i_types_pkg.sv
// rtl/rv32i_types_pkg.sv - shared types for the instruction fetch buffer
//
// Purpose: word type, fetch FSM states, buffered fetch entry and PC helpers.
// Ports:   none (package).
package rv32i_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic {
        FETCH   = 1'b0,
        DISCARD = 1'b1
    } fetch_state_t;

    typedef struct packed {
        word_t pc;
        word_t instr;
        logic  fault;
    } fetch_entry_t;

    localparam word_t PC_STEP = 32'd4;

    // Fetches are always word aligned; the low two target bits are ignored.
    function automatic word_t align_pc(input word_t addr);
        return addr & ~word_t'(32'h3);
    endfunction

endpackage

// File: rtl/fetch_buffer_if.sv
// rtl/fetch_buffer_if.sv - instruction bus, redirect and decode handshake bundle
//
// Purpose: groups the fetch buffer's bus, redirect and decode signals.
// Modports:
//   master - fetch buffer side: drives imem_ren/imem_addr and dec_* outputs
//   slave  - environment side: drives bus responses, redirect and dec_ready
interface fetch_buffer_if;
    import rv32i_types_pkg::*;

    logic  imem_ren;
    word_t imem_addr;
    logic  imem_busy;
    word_t imem_rdata;
    logic  imem_error;
    logic  redirect;
    word_t redirect_pc;
    logic  dec_ready;
    logic  dec_valid;
    word_t dec_instr;
    word_t dec_pc;
    logic  dec_fault;

    modport master (
        output imem_ren, imem_addr, dec_valid, dec_instr, dec_pc, dec_fault,
        input  imem_busy, imem_rdata, imem_error, redirect, redirect_pc, dec_ready
    );

    modport slave (
        input  imem_ren, imem_addr, dec_valid, dec_instr, dec_pc, dec_fault,
        output imem_busy, imem_rdata, imem_error, redirect, redirect_pc, dec_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO holding fetched instruction entries
//
// Purpose: DEPTH-entry sync FIFO of fetch_entry_t with flush.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   push, push_data     - write request and entry
//   pop                 - advance head
//   flush               - drop all entries
//   pop_data            - head entry
//   full, empty, count  - occupancy status
module fetch_fifo
    import rv32i_types_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    input  logic                       flush,
    output fetch_entry_t               pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full     = (count == (PW + 1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full && !flush;
    assign do_pop   = pop && !empty && !flush;
    assign pop_data = mem[rd_ptr];

    // Pointers are exactly PW bits wide, so they wrap modulo DEPTH naturally.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - instruction fetch buffer with redirect handling
//
// Purpose: issues sequential word fetches, buffers results in fetch_fifo and
//          presents them to decode; redirects flush the buffer and discard an
//          in-flight bus transaction.
// Ports:
//   CLK  - clock
//   RST  - synchronous active-high reset
//   bus  - fetch_buffer_if.master (imem_*, redirect*, dec_*)
// Config macro: FETCH_BYPASS_EN - when defined, a completion into an empty
//   buffer is presented to decode in the same cycle.
module fetch_buffer
    import rv32i_types_pkg::*;
#(
    parameter int    DEPTH    = 4,
    parameter word_t RESET_PC = 32'h8000_0000
) (
    input  logic               CLK,
    input  logic               RST,
    fetch_buffer_if.master     bus
);

    fetch_state_t              state;
    fetch_state_t              state_next;
    word_t                     fetch_pc;
    word_t                     fetch_pc_next;
    word_t                     target;
    word_t                     target_next;
    word_t                     new_target;

    logic                      complete;
    logic                      pending;
    logic                      push;
    logic                      pop;
    logic                      bypass;
    logic                      out_valid;
    logic                      full;
    logic                      empty;
    logic [$clog2(DEPTH):0]    count;
    fetch_entry_t              in_entry;
    fetch_entry_t              head;
    fetch_entry_t              out_entry;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (push),
        .push_data (in_entry),
        .pop       (pop),
        .flush     (bus.redirect),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC;
            target   <= RESET_PC;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            target   <= target_next;
        end
    end

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        target_next   = target;
        push          = 1'b0;
        bypass        = 1'b0;

        // DISCARD must keep the request up until the old transaction completes.
        bus.imem_ren  = (state == DISCARD) ? 1'b1 : !full;
        bus.imem_addr = fetch_pc;
        complete      = bus.imem_ren && !bus.imem_busy;
        pending       = bus.imem_ren && bus.imem_busy;
        new_target    = align_pc(bus.redirect_pc);
        in_entry      = '{pc: fetch_pc, instr: bus.imem_rdata, fault: bus.imem_error};

        case (state)
            FETCH: begin
                if (bus.redirect) begin
                    // An in-flight request cannot be cancelled on the bus, so
                    // hold its address and remember where to go afterwards.
                    if (pending) begin
                        state_next  = DISCARD;
                        target_next = new_target;
                    end else begin
                        fetch_pc_next = new_target;
                    end
                end else if (complete) begin
                    fetch_pc_next = fetch_pc + PC_STEP;
`ifdef FETCH_BYPASS_EN
                    bypass = empty;
                    push   = !(empty && bus.dec_ready);
`else
                    push   = 1'b1;
`endif
                end
            end
            DISCARD: begin
                if (bus.redirect) begin
                    target_next = new_target;
                end
                if (complete) begin
                    state_next    = FETCH;
                    fetch_pc_next = bus.redirect ? new_target : target;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase

        pop       = !empty && bus.dec_ready && !bus.redirect;
        out_valid = !empty || bypass;
        out_entry = empty ? in_entry : head;

        // Outputs read as zero whenever nothing is presented.
        bus.dec_valid = out_valid;
        bus.dec_instr = out_valid ? out_entry.instr : '0;
        bus.dec_pc    = out_valid ? out_entry.pc    : '0;
        bus.dec_fault = out_valid && out_entry.fault;
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb/tb_fetch_buffer.sv - directed self-checking bench for fetch_buffer
module tb_fetch_buffer;
    import rv32i_types_pkg::*;

    logic  clk;
    logic  rst;
    word_t err_addr;
    int    checks;
    int    errors;

    word_t        addr_q[$];
    fetch_entry_t pop_q[$];

    fetch_buffer_if ifc ();

    fetch_buffer #(
        .DEPTH    (4),
        .RESET_PC (32'h8000_0000)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (ifc.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic word_t instr_of(input word_t a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    always_comb begin
        ifc.imem_rdata = instr_of(ifc.imem_addr);
        ifc.imem_error = (ifc.imem_addr == err_addr);
    end

    // Completions and pops as seen between edges.
    always @(negedge clk) begin
        if (!rst) begin
            if (ifc.imem_ren && !ifc.imem_busy) addr_q.push_back(ifc.imem_addr);
            if (ifc.dec_valid && ifc.dec_ready)
                pop_q.push_back('{pc: ifc.dec_pc, instr: ifc.dec_instr, fault: ifc.dec_fault});
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        ifc.imem_busy   = 1'b1;
        ifc.redirect    = 1'b0;
        ifc.redirect_pc = '0;
        ifc.dec_ready   = 1'b0;
        err_addr        = 32'h0000_0001;
        cycle(2);
        rst = 1'b0;
        addr_q.delete();
        pop_q.delete();
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Reset state, sampled mid-cycle.
        do_reset();
        @(negedge clk);
        check_eq("rst_ren",   ifc.imem_ren,   1);
        check_eq("rst_addr",  ifc.imem_addr,  32'h8000_0000);
        check_eq("rst_valid", ifc.dec_valid,  0);
        check_eq("rst_instr", ifc.dec_instr,  0);
        check_eq("rst_pc",    ifc.dec_pc,     0);
        check_eq("rst_fault", ifc.dec_fault,  0);

        // Streaming fetch, no backpressure.
        do_reset();
        ifc.imem_busy = 1'b0;
        ifc.dec_ready = 1'b1;
        cycle(6);
        ifc.imem_busy = 1'b1;
        cycle(3);
        check_eq("seq_addr0", addr_q[0], 32'h8000_0000);
        check_eq("seq_addr1", addr_q[1], 32'h8000_0004);
        check_eq("seq_addr2", addr_q[2], 32'h8000_0008);
        check_eq("seq_npop",  pop_q.size(), 6);
        for (int i = 0; i < 3; i++) begin
            check_eq("seq_pc",    pop_q[i].pc,    32'h8000_0000 + 32'(4 * i));
            check_eq("seq_instr", pop_q[i].instr, instr_of(32'h8000_0000 + 32'(4 * i)));
        end

        // Backpressure fills exactly DEPTH entries, order preserved on resume.
        do_reset();
        ifc.imem_busy = 1'b0;
        cycle(10);
        check_eq("full_npush", addr_q.size(), 4);
        check_eq("full_ren",   ifc.imem_ren, 0);
        check_eq("full_count", dut.u_fifo.count, 4);
        check_eq("full_head",  ifc.dec_pc, 32'h8000_0000);
        ifc.imem_busy = 1'b1;
        ifc.dec_ready = 1'b1;
        cycle(6);
        check_eq("full_npop", pop_q.size(), 4);
        for (int i = 0; i < 4; i++)
            check_eq("full_order", pop_q[i].pc, 32'h8000_0000 + 32'(4 * i));

        // Redirect while busy: address held, data dropped, then the new target.
        do_reset();
        ifc.imem_busy = 1'b0;
        cycle(1);
        ifc.imem_busy   = 1'b1;
        ifc.redirect    = 1'b1;
        ifc.redirect_pc = 32'h0000_1002;
        cycle(1);
        ifc.redirect = 1'b0;
        check_eq("disc_addr",   ifc.imem_addr, 32'h8000_0004);
        check_eq("disc_ren",    ifc.imem_ren,  1);
        check_eq("disc_valid",  ifc.dec_valid, 0);
        cycle(2);
        check_eq("disc_hold",   ifc.imem_addr, 32'h8000_0004);
        check_eq("disc_valid2", ifc.dec_valid, 0);
        ifc.imem_busy = 1'b0;
        cycle(1);
        ifc.imem_busy = 1'b1;
        check_eq("disc_next",   ifc.imem_addr, 32'h0000_1000);
        check_eq("disc_drop",   ifc.dec_valid, 0);
        ifc.imem_busy = 1'b0;
        cycle(1);
        ifc.imem_busy = 1'b1;
        check_eq("disc_nvalid", ifc.dec_valid, 1);
        check_eq("disc_npc",    ifc.dec_pc,    32'h0000_1000);
        check_eq("disc_ninstr", ifc.dec_instr, instr_of(32'h0000_1000));

        // Redirect in the completion cycle with two entries buffered.
        do_reset();
        ifc.imem_busy = 1'b0;
        cycle(2);
        check_eq("cc_count2", dut.u_fifo.count, 2);
        ifc.redirect    = 1'b1;
        ifc.redirect_pc = 32'h0000_2000;
        ifc.dec_ready   = 1'b1;
        cycle(1);
        ifc.redirect  = 1'b0;
        ifc.imem_busy = 1'b1;
        ifc.dec_ready = 1'b0;
        check_eq("cc_count0", dut.u_fifo.count, 0);
        check_eq("cc_valid",  ifc.dec_valid, 0);
        check_eq("cc_addr",   ifc.imem_addr, 32'h0000_2000);
        check_eq("cc_ren",    ifc.imem_ren,  1);
        ifc.imem_busy = 1'b0;
        cycle(1);
        ifc.imem_busy = 1'b1;
        check_eq("cc_head",   ifc.dec_pc, 32'h0000_2000);

        // Address wrap and single-entry fault marking.
        do_reset();
        ifc.imem_busy   = 1'b0;
        ifc.redirect    = 1'b1;
        ifc.redirect_pc = 32'hFFFF_FFF8;
        cycle(1);
        ifc.redirect = 1'b0;
        err_addr     = 32'hFFFF_FFFC;
        addr_q.delete();
        cycle(3);
        ifc.imem_busy = 1'b1;
        check_eq("wrap_a0", addr_q[0], 32'hFFFF_FFF8);
        check_eq("wrap_a1", addr_q[1], 32'hFFFF_FFFC);
        check_eq("wrap_a2", addr_q[2], 32'h0000_0000);
        ifc.dec_ready = 1'b1;
        cycle(4);
        check_eq("wrap_npop", pop_q.size(), 3);
        check_eq("wrap_pc2",  pop_q[2].pc,    32'h0000_0000);
        check_eq("wrap_f0",   pop_q[0].fault, 0);
        check_eq("wrap_f1",   pop_q[1].fault, 1);
        check_eq("wrap_f2",   pop_q[2].fault, 0);
        check_eq("wrap_i1",   pop_q[1].instr, instr_of(32'hFFFF_FFFC));

        // Second redirect during DISCARD replaces the saved target.
        do_reset();
        ifc.redirect    = 1'b1;
        ifc.redirect_pc = 32'h0000_1000;
        cycle(1);
        ifc.redirect_pc = 32'h0000_3004;
        cycle(1);
        ifc.redirect  = 1'b0;
        ifc.imem_busy = 1'b0;
        cycle(1);
        ifc.imem_busy = 1'b1;
        check_eq("redisc_addr",  ifc.imem_addr, 32'h0000_3004);
        check_eq("redisc_valid", ifc.dec_valid, 0);

        // Completion into an empty buffer with decode ready.
        do_reset();
        ifc.dec_ready = 1'b1;
        ifc.imem_busy = 1'b0;
        @(negedge clk);
`ifdef FETCH_BYPASS_EN
        check_eq("byp_same_valid", ifc.dec_valid, 1);
        check_eq("byp_same_pc",    ifc.dec_pc,    32'h8000_0000);
`else
        check_eq("byp_same_valid", ifc.dec_valid, 0);
`endif
        @(posedge clk);
        #1;
        ifc.imem_busy = 1'b1;
`ifdef FETCH_BYPASS_EN
        check_eq("byp_next_valid", ifc.dec_valid, 0);
        check_eq("byp_count",      dut.u_fifo.count, 0);
`else
        check_eq("byp_next_valid", ifc.dec_valid, 1);
        check_eq("byp_next_pc",    ifc.dec_pc,    32'h8000_0000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameters SHALL be one per line:
- DEPTH, 4, number of buffered instructions (power of two, >=2)
- RESET_PC, 32'h8000_0000, first fetch address after reset
REQ-003 Ports SHALL be one per line:
- CLK, in, 1, clock
- RST, in, 1, synchronous active-high reset
- imem_ren, out, 1, instruction bus read request
- imem_addr, out, 32, word-aligned fetch address
- imem_busy, in, 1, bus busy; ren && !busy = transaction complete
- imem_rdata, in, 32, read data, valid at completion
- imem_error, in, 1, bus fault, valid at completion
- redirect, in, 1, branch/jump/trap/fence redirect
- redirect_pc, in, 32, new fetch target
- dec_ready, in, 1, decode/control-unit consumes head entry
- dec_valid, out, 1, head entry valid
- dec_instr, out, 32, instruction word to control unit instr
- dec_pc, out, 32, PC of dec_instr
- dec_fault, out, 1, instruction access fault flag, drives fault_insn path

Function
REQ-004 The FSM SHALL have states FETCH and DISCARD.
REQ-005 In FETCH, imem_ren SHALL be 1 whenever count < DEPTH; imem_addr SHALL equal fetch_pc and stay stable while imem_busy=1.
REQ-006 On completion in FETCH, {fetch_pc, imem_rdata, imem_error} SHALL be pushed, and fetch_pc SHALL advance by 4 (mod 2^32, wrap from FFFF_FFFC to 0).
REQ-007 dec_valid SHALL equal (count != 0); outputs SHALL show the head entry; pop SHALL occur when dec_valid && dec_ready.
REQ-008 A push and a pop in the same cycle SHALL leave count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-009 Push-to-dec_valid latency SHALL be one cycle.
REQ-010 On redirect, count SHALL become 0 next cycle; fetch_pc SHALL become {redirect_pc[31:2],2'b00}; a same-cycle pop/push SHALL be discarded.
REQ-011 Redirect while a transaction is pending (ren && busy) SHALL enter DISCARD; imem_addr SHALL hold the old address until completion.
REQ-012 In DISCARD, completion data SHALL be dropped, then the state SHALL return to FETCH with the saved target; a further redirect in DISCARD SHALL overwrite the saved target.
REQ-013 Redirect in the completion cycle SHALL drop that data and stay in FETCH; the next request SHALL use the redirect target.
REQ-014 imem_error entries SHALL still advance fetch_pc; dec_fault marks only that entry.

Reset
REQ-015 While RST=1, next state SHALL be FETCH, count=0, pointers=0, and fetch_pc=RESET_PC.
REQ-016 In the cycle after reset, imem_ren=1, imem_addr=RESET_PC, and dec_valid=0; dec_instr, dec_pc and dec_fault SHALL be 0.
REQ-017 Reset during a pending bus transaction SHALL abandon it without entering DISCARD.

Configuration
REQ-018 With FETCH_BYPASS_EN defined, a FETCH completion with count=0 and no redirect SHALL drive the outputs combinationally the same cycle with dec_valid=1; if dec_ready=1, no push SHALL occur.
REQ-019 Without FETCH_BYPASS_EN, all data SHALL pass through storage with the REQ-009 latency.

Structure
REQ-020 fetch_state_t {FETCH, DISCARD} and fetch_entry_t {pc, instr, fault} SHALL live in rv32i_types_pkg, using word_t.
REQ-021 Storage SHALL be a sub-module fetch_fifo (sync FIFO, parameter DEPTH, push/pop/flush, full/empty/count); the FSM and PC logic SHALL stay in fetch_buffer.

Verification
REQ-022 Reset, busy=0, dec_ready=1 -> addresses 8000_0000, 8000_0004, 8000_0008 in order; each dec_pc matches its rdata.
REQ-023 dec_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 pushes, imem_ren=0, count=4; resume -> order preserved.
REQ-024 Redirect to 0000_1002 while busy=1 on 8000_0004 -> addr held until completion, data dropped, next addr 0000_1000, dec_valid=0 meanwhile.
REQ-025 Redirect in completion cycle with dec_ready=1 and count=2 -> count=0 next cycle, no pop observed, next addr = target.
REQ-026 fetch_pc=FFFF_FFFC completes -> next addr 0000_0000; imem_error=1 on that fetch -> dec_fault=1 only for that entry.
REQ-027 FETCH_BYPASS_EN, empty, completion with dec_ready=1 -> dec_valid=1 the same cycle, count stays 0; without the macro -> dec_valid one cycle later.
